alu: RTL and testbench

Combinational 32-bit integer ALU for the MIPS datapath, sitting in the execute stage between the register-file/immediate operand muxes and the writeback/branch logic. It performs logic, add/subtract, set-less-than, fixed and variable shifts, and signed/unsigned 32×32 multiply. Results appear on a 64-bit `{hi, lo}` pair together with a `zero` flag. Outputs are a pure function of the current inputs within the same cycle.

---
 rtl/alu.sv | 121 ++++++++++++
 tb/tb_alu.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- combinational 32-bit integer ALU for the MIPS execute stage.
//
// Performs logic, add/subtract, set-less-than, fixed and variable shifts and
// signed/unsigned 32x32 multiply. Every output is a pure function of the
// current op/a/b/shamt inputs; there are no registers anywhere in the block.
//
// Ports
//   clk    in   1   system clock (integration only, unused by the datapath)
//   reset  in   1   synchronous active-high reset (integration only, no effect)
//   op     in   4   operation select
//   a      in  32   operand A; a[4:0] is the variable shift amount
//   b      in  32   operand B; the value shifted by every shift op
//   shamt  in   5   shift amount for fixed shifts
//   hi     out 32   upper product word for MULT/MULTU, else 0
//   lo     out 32   result, or lower product word for MULT/MULTU
//   zero   out  1   1 when {hi, lo} == 0
// -----------------------------------------------------------------------------
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        zero
);

  typedef enum logic [3:0] {
    OP_AND   = 4'h0,
    OP_OR    = 4'h1,
    OP_ADD   = 4'h2,
    OP_XOR   = 4'h3,
    OP_NOR   = 4'h4,
    OP_SLL   = 4'h5,
    OP_SUB   = 4'h6,
    OP_SLT   = 4'h7,
    OP_SLTU  = 4'h8,
    OP_SRL   = 4'h9,
    OP_SRA   = 4'hA,
    OP_SLLV  = 4'hB,
    OP_SRLV  = 4'hC,
    OP_SRAV  = 4'hD,
    OP_MULT  = 4'hE,
    OP_MULTU = 4'hF
  } op_e;

  // clk and reset exist only so the block drops into the pipeline wrapper
  // with a uniform port list; they are consumed here and nowhere else.
  logic unused_inputs;
  assign unused_inputs = clk ^ reset;

  op_e op_sel;
  assign op_sel = op_e'(op);

  // Shared shifter: the fixed and variable variants differ only in where the
  // amount comes from, so one barrel shifter serves all six shift ops.
  logic        var_shift;
  logic [4:0]  shift_amt;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;

  assign var_shift = (op_sel == OP_SLLV) || (op_sel == OP_SRLV) || (op_sel == OP_SRAV);
  assign shift_amt = var_shift ? a[4:0] : shamt;
  assign sll_res   = b << shift_amt;
  assign srl_res   = b >> shift_amt;
  assign sra_res   = $unsigned($signed(b) >>> shift_amt);

  // Adder/subtractor and comparisons.
  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic        slt_res;
  logic        sltu_res;

  assign add_res  = a + b;
  assign sub_res  = a - b;
  assign slt_res  = $signed(a) < $signed(b);
  assign sltu_res = a < b;

  // Multipliers: operands are extended to 64 bits before multiplying so the
  // product is computed at full width rather than truncated to 32.
  logic signed [63:0] mult_s;
  logic        [63:0] mult_u;

  assign mult_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign mult_u = {32'h0, a} * {32'h0, b};

  // Result select.
  always_comb begin
    // NOTE: combinational outputs get a default before the case so that no
    // path leaves them unassigned and a latch is never inferred; blocking
    // assignments are correct here because this block holds no state.
    hi = 32'h0;
    lo = 32'h0;
    unique case (op_sel)
      OP_AND:   lo = a & b;
      OP_OR:    lo = a | b;
      OP_ADD:   lo = add_res;
      OP_XOR:   lo = a ^ b;
      OP_NOR:   lo = ~(a | b);
      OP_SLL:   lo = sll_res;
      OP_SUB:   lo = sub_res;
      OP_SLT:   lo = {31'h0, slt_res};
      OP_SLTU:  lo = {31'h0, sltu_res};
      OP_SRL:   lo = srl_res;
      OP_SRA:   lo = sra_res;
      OP_SLLV:  lo = sll_res;
      OP_SRLV:  lo = srl_res;
      OP_SRAV:  lo = sra_res;
      OP_MULT:  {hi, lo} = $unsigned(mult_s);
      OP_MULTU: {hi, lo} = mult_u;
    endcase
  end

  // Zero flag covers the full 64-bit result so it is meaningful for products.
  assign zero = ({hi, lo} == 64'h0);

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- scoreboard bench for the combinational ALU.
//
// A stimulus process drives inputs 1 unit after each rising edge and pushes
// the expected {hi, lo, zero} into a queue; a monitor samples on the falling
// edge, pops the oldest expectation and compares. Directed vectors carry
// hand-derived constants; random vectors use an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        zero;

  always #5 clk = ~clk;

  alu dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .a     (a),
    .b     (b),
    .shamt (shamt),
    .hi    (hi),
    .lo    (lo),
    .zero  (zero)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam longint unsigned MOD32 = 64'h1_0000_0000;

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic logic [63:0] ref_model(input logic [3:0] f_op,
                                            input logic [31:0] f_a,
                                            input logic [31:0] f_b,
                                            input logic [4:0] f_sh);
    longint unsigned ua, ub, p2, r;
    longint          sa, sb, q;
    int              amt;
    ua  = f_a;
    ub  = f_b;
    sa  = longint'($signed(f_a));
    sb  = longint'($signed(f_b));
    amt = (f_op >= 4'hB && f_op <= 4'hD) ? int'(f_a % 32) : int'(f_sh);
    p2  = 64'd1 << amt;
    r   = 0;
    case (f_op)
      4'h0: r = ua & ub;
      4'h1: r = ua | ub;
      4'h2: r = (ua + ub) % MOD32;
      4'h3: r = ua ^ ub;
      4'h4: r = (MOD32 - 1) - (ua | ub);
      4'h5, 4'hB: r = (ub * p2) % MOD32;
      4'h6: r = (ua + MOD32 - ub) % MOD32;
      4'h7: r = (sa < sb) ? 1 : 0;
      4'h8: r = (ua < ub) ? 1 : 0;
      4'h9, 4'hC: r = ub / p2;
      4'hA, 4'hD: begin
        // floor division of the signed value by 2^amt
        longint sp2;
        sp2 = longint'(p2);
        if (sb >= 0) q = sb / sp2;
        else         q = -((-sb + sp2 - 1) / sp2);
        r = longint'(q) % longint'(MOD32);
        if (q < 0) r = (longint'(q) + longint'(MOD32)) % MOD32;
      end
      4'hE: r = longint'(sa * sb);
      4'hF: r = ua * ub;
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic issue(input string name, input logic [3:0] t_op,
                       input logic [31:0] t_a, input logic [31:0] t_b,
                       input logic [4:0] t_sh, input logic [31:0] e_hi,
                       input logic [31:0] e_lo, input logic e_zero);
    exp_t e;
    @(posedge clk);
    #1;
    op    = t_op;
    a     = t_a;
    b     = t_b;
    shamt = t_sh;
    e.name = name;
    e.hi   = e_hi;
    e.lo   = e_lo;
    e.zero = e_zero;
    sb_q.push_back(e);
  endtask

  task automatic issue_model(input string name, input logic [3:0] t_op,
                             input logic [31:0] t_a, input logic [31:0] t_b,
                             input logic [4:0] t_sh);
    logic [63:0] r;
    r = ref_model(t_op, t_a, t_b, t_sh);
    issue(name, t_op, t_a, t_b, t_sh, r[63:32], r[31:0], r == 64'h0);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (op=%h a=%h b=%h shamt=%0d)",
               name, act, exp, op, a, b, shamt);
    end
  endtask

  // Monitor: the ALU presents a result every cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.name, ".hi"},   hi, e.hi);
      check({e.name, ".lo"},   lo, e.lo);
      check({e.name, ".zero"}, {31'h0, zero}, {31'h0, e.zero});
    end
  end

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    op    = 4'h0;
    a     = 32'h0;
    b     = 32'h0;
    shamt = 5'd0;

    // Directed vectors with hand-derived expectations.
    issue("add_wrap", 4'h2, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 32'h0, 1'b1);
    issue("sub_wrap", 4'h6, 32'h0, 32'h1, 5'd0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    issue("nor",      4'h4, 32'hF0F0_F0F0, 32'h0F0F_0000, 5'd0, 32'h0, 32'h0000_0F0F, 1'b0);
    issue("xor",      4'h3, 32'hF0F0_F0F0, 32'h0F0F_0000, 5'd0, 32'h0, 32'hFFFF_F0F0, 1'b0);
    issue("and",      4'h0, 32'hF0F0_F0F0, 32'h0F0F_0000, 5'd0, 32'h0, 32'h0000_0000, 1'b1);
    issue("or",       4'h1, 32'hF0F0_F0F0, 32'h0F0F_0000, 5'd0, 32'h0, 32'hFFFF_F0F0, 1'b0);
    issue("slt",      4'h7, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 32'h1, 1'b0);
    issue("sltu",     4'h8, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 32'h0, 1'b1);
    issue("sra4",     4'hA, 32'h0, 32'h8000_0000, 5'd4, 32'h0, 32'hF800_0000, 1'b0);
    issue("srl4",     4'h9, 32'h0, 32'h8000_0000, 5'd4, 32'h0, 32'h0800_0000, 1'b0);
    issue("sllv_hi",  4'hB, 32'hFFFF_FFE3, 32'h1, 5'd0, 32'h0, 32'h0000_0008, 1'b0);
    issue("sll0",     4'h5, 32'h0, 32'hDEAD_BEEF, 5'd0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    issue("sll31",    4'h5, 32'h0, 32'h0000_0003, 5'd31, 32'h0, 32'h8000_0000, 1'b0);
    issue("srav31",   4'hD, 32'h0000_003F, 32'h8000_0000, 5'd0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    issue("srlv31",   4'hC, 32'hFFFF_FFFF, 32'h8000_0000, 5'd0, 32'h0, 32'h0000_0001, 1'b0);
    issue("mult",     4'hE, 32'hFFFF_FFFF, 32'h2, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    issue("multu",    4'hF, 32'hFFFF_FFFF, 32'h2, 5'd0, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    issue("multu0",   4'hF, 32'h0, 32'h1234_5678, 5'd0, 32'h0, 32'h0, 1'b1);
    issue("mult_hi",  4'hE, 32'h0001_0000, 32'h0001_0000, 5'd0, 32'h0000_0001, 32'h0, 1'b0);

    // Reset and clock have no effect on the result.
    reset = 1'b1;
    for (int i = 0; i < 3; i++)
      issue("rst_add", 4'h2, 32'h3, 32'h4, 5'd0, 32'h0, 32'h7, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++)
      issue("post_rst", 4'h2, 32'h3, 32'h4, 5'd0, 32'h0, 32'h7, 1'b0);

    // Randomized vectors against the reference model, every op covered.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] r_op;
      r_op = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
      issue_model("rand", r_op, pick_operand(), pick_operand(),
                  5'($urandom_range(0, 31)));
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results still pending, required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
